// File: rtl/core_muldiv.sv
// core_muldiv: iterative RV32M/RV64M multiply/divide unit.
// Multiplies by shift-add and divides by restoring division. Both work on
// operand magnitudes; signs are applied when the result is written on entry to
// DONE. Divide-by-zero and signed overflow bypass the iteration entirely.
// All state changes on the falling edge of i_CLK.
module core_muldiv #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            i_CLK,
    input  logic            i_RST,
    input  logic            i_flush,
    input  logic            i_start,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_stall,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              neg_r;

    logic              rs1_signed;
    logic              rs2_signed;
    logic              rs1_neg;
    logic              rs2_neg;
    logic [XLEN-1:0]   rs1_mag;
    logic [XLEN-1:0]   rs2_mag;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   fast_res;
    logic [2*XLEN-1:0] start_acc;
    logic [XLEN-1:0]   start_opnd;
    logic [2*XLEN-1:0] acc_nxt;

    // Shift-add: acc holds {partial product high half, remaining multiplier
    // bits}. Each retired bit conditionally adds the multiplicand into the
    // high half and shifts the whole accumulator right by one.
    function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] a,
                                                   input logic [XLEN-1:0]   m);
        logic [2*XLEN-1:0] r;
        logic [XLEN:0]     sum;
        r = a;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            sum = {1'b0, r[2*XLEN-1:XLEN]} + (r[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
            r   = {sum, r[XLEN-1:1]};
        end
        return r;
    endfunction

    // Restoring division: acc holds {partial remainder, dividend/quotient}.
    // Each retired bit shifts the next dividend bit into the remainder and
    // keeps the trial subtraction when it does not borrow. The remainder stays
    // below the divisor, so XLEN+1 bits are enough for the trial value.
    function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] a,
                                                   input logic [XLEN-1:0]   d);
        logic [2*XLEN-1:0] r;
        logic [XLEN:0]     rext;
        logic [XLEN:0]     diff;
        r = a;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            rext = {r[2*XLEN-1:XLEN], r[XLEN-1]};
            diff = rext - {1'b0, d};
            if (!diff[XLEN]) begin
                r = {diff[XLEN-1:0], r[XLEN-2:0], 1'b1};
            end else begin
                r = {rext[XLEN-1:0], r[XLEN-2:0], 1'b0};
            end
        end
        return r;
    endfunction

    // Turns the finished magnitude accumulator into the architectural result.
    function automatic logic [XLEN-1:0] finalize(input logic [2:0]        op,
                                                 input logic [2*XLEN-1:0] a,
                                                 input logic              nq,
                                                 input logic              nr);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = nq ? -a : a;
        quo  = nq ? -a[XLEN-1:0] : a[XLEN-1:0];
        rem  = nr ? -a[2*XLEN-1:XLEN] : a[2*XLEN-1:XLEN];
        if (!op[2]) begin
            return (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin
            return op[1] ? rem : quo;
        end
    endfunction

    // Decode the requested operation: signedness, magnitudes, fast paths.
    always_comb begin
        rs1_signed = (i_op == OP_MULH) || (i_op == OP_MULHSU) ||
                     (i_op == OP_DIV)  || (i_op == OP_REM);
        rs2_signed = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
        rs1_neg    = rs1_signed & i_rs1[XLEN-1];
        rs2_neg    = rs2_signed & i_rs2[XLEN-1];
        rs1_mag    = rs1_neg ? -i_rs1 : i_rs1;
        rs2_mag    = rs2_neg ? -i_rs2 : i_rs2;
        div_zero   = i_op[2] & (i_rs2 == ZERO);
        div_ovf    = ((i_op == OP_DIV) || (i_op == OP_REM)) &
                     (i_rs1 == MIN_NEG) & (i_rs2 == {XLEN{1'b1}});
        fast_res   = ZERO;
        if (div_zero) begin
            fast_res = i_op[1] ? i_rs1 : {XLEN{1'b1}};
        end else begin
            fast_res = i_op[1] ? ZERO : MIN_NEG;
        end
        // Multiply iterates over the multiplier (rs2); divide over the dividend (rs1).
        start_acc  = i_op[2] ? {ZERO, rs1_mag} : {ZERO, rs2_mag};
        start_opnd = i_op[2] ? rs2_mag : rs1_mag;
    end

    // One iteration of whichever algorithm the latched operation uses.
    always_comb begin
        acc_nxt = op_q[2] ? div_step(acc, opnd) : mul_step(acc, opnd);
    end

    // Control FSM, iteration datapath and registered result/done.
    always_ff @(negedge i_CLK) begin
        if (i_RST) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            o_result <= '0;
            o_done   <= 1'b0;
        end else if (i_flush) begin
            state  <= IDLE;
            cnt    <= '0;
            o_done <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    o_done <= 1'b0;
                    state  <= IDLE;
                    if (i_start) begin
                        op_q  <= i_op;
                        neg_q <= rs1_neg ^ rs2_neg;
                        neg_r <= rs1_neg;
                        cnt   <= '0;
                        if (div_zero || div_ovf) begin
                            o_result <= fast_res;
                            o_done   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            acc   <= start_acc;
                            opnd  <= start_opnd;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    if (cnt == CW'(N - 1)) begin
                        cnt      <= '0;
                        o_result <= finalize(op_q, acc_nxt, neg_q, neg_r);
                        o_done   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                end
            endcase
        end
    end

    // Hold the pipeline while a request is being accepted or iterating.
    always_comb begin
        o_busy  = (state == CALC);
        o_stall = ~i_RST & ((i_start & (state != CALC) & ~i_flush) | (state == CALC));
    end

endmodule

// File: doc/core_muldiv.md
CORE_MULDIV -- requirements
Module: core_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 16, 32, 64.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1, bits retired per iteration cycle; legal values 1, 2, 4; must divide XLEN.
REQ-003 SHALL have port i_CLK  in  1  the single clock; all state updates occur on the falling edge of i_CLK.
REQ-004 SHALL have port i_RST  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_flush  in  1  pipeline flush; aborts any operation in progress.
REQ-006 SHALL have port i_start  in  1  request a new operation with the current i_op, i_rs1 and i_rs2.
REQ-007 SHALL have port i_op  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port i_rs1  in  XLEN  operand 1 (multiplicand or dividend).
REQ-009 SHALL have port i_rs2  in  XLEN  operand 2 (multiplier or divisor).
REQ-010 SHALL have port o_stall  out  1  pipeline hold request; the core drives pause_n from its inverse.
REQ-011 SHALL have port o_busy  out  1  high while the state is CALC.
REQ-012 SHALL have port o_done  out  1  one-cycle result-valid pulse.
REQ-013 SHALL have port o_result  out  XLEN  final result; held stable until the next accepted start.

Function
REQ-014 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-015 SHALL accept i_start only in IDLE or DONE, latching i_op and the operands on that edge; i_start in CALC SHALL be ignored.
REQ-016 SHALL define N = XLEN/BPC, where BPC is BITS_PER_CYCLE; a normal operation spends exactly N edges in CALC, then 1 cycle in DONE, then returns to IDLE unless a new start is accepted.
REQ-017 SHALL, counting the cycle in which i_start is sampled as cycle 0, hold CALC for cycles 1..N and assert o_done in cycle N+1 (cycle 33 for XLEN=32, BPC=1).
REQ-018 SHALL drive o_stall = (i_start & state!=CALC & ~i_flush) | (state==CALC); o_stall SHALL be low in the DONE cycle.
REQ-019 SHALL assert o_done only in DONE and only for one cycle; o_result SHALL be valid in that cycle and thereafter.
REQ-020 SHALL multiply by unsigned shift-add on magnitudes into a 2*XLEN accumulator, with BPC multiplier bits per edge.
REQ-021 SHALL select the multiply result as follows: MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
REQ-022 SHALL treat operand signedness as follows: MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU unsigned x unsigned.
REQ-023 SHALL divide by unsigned restoring division on magnitudes, with BPC quotient bits per edge.
REQ-024 SHALL apply signs on entry to DONE: the quotient is negated when the operand signs differ, and the remainder takes the sign of the dividend.
REQ-025 SHALL take a fast path for divide by zero (i_rs2=0): skip CALC and enter DONE in cycle 1.
REQ-026 SHALL, for divide by zero, return DIV/DIVU = all ones and REM/REMU = i_rs1.
REQ-027 SHALL take a fast path for signed overflow (DIV/REM with i_rs1=most-negative and i_rs2=all ones): skip CALC and enter DONE in cycle 1.
REQ-028 SHALL, for signed overflow, return DIV = most-negative and REM = 0.
REQ-029 SHALL produce exact RV32M/RV64M results for all operand values, including most-negative x most-negative.
REQ-030 SHALL keep the iteration counter at ceil(log2(N+1)) bits with no wrap; CALC exits when the counter reaches N-1.
REQ-031 SHALL, on i_flush in any state, go to IDLE on the next edge: o_done low, o_result unchanged, no result produced.
REQ-032 SHALL give i_flush priority over a simultaneous i_start.
REQ-033 SHALL, on i_start asserted in DONE (back-to-back), pulse o_done for the old result in that cycle and start the new operation on the same edge.

Reset
REQ-034 SHALL, with i_RST high at an edge, force state=IDLE, o_result=0, o_done=0, o_busy=0, and clear the counter and accumulators.
REQ-035 SHALL drive o_stall=0 while i_RST is high.
REQ-036 SHALL give i_RST priority over i_flush and i_start, and SHALL abort an operation in progress mid-CALC with no o_done.

Verification
REQ-037 SHALL verify MUL: XLEN=32, BPC=1, MUL 7 x 0xFFFFFFFD -> o_done in cycle 33, o_result=0xFFFFFFEB, o_stall high in cycles 0..32.
REQ-038 SHALL verify MULH and MULHU with 0x80000000 x 0x80000000: MULH -> 0x40000000; MULHU -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-039 SHALL verify signed divide: DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; both with o_done in cycle 33.
REQ-040 SHALL verify the fast paths: DIVU 5 / 0 -> 0xFFFFFFFF, REMU -> 5, DIV 0x80000000 / -1 -> 0x80000000, REM -> 0, all with o_done in cycle 1.
REQ-041 SHALL verify abort: i_flush in cycle 10 of a DIV -> IDLE in cycle 11, no o_done, o_result still 0; same check with i_RST in place of i_flush.
REQ-042 SHALL verify throughput: BPC=4, two back-to-back MULs with i_start held through DONE -> o_done in cycles 9 and 18, with correct results.
